// File: rtl/register_file_dual_write.sv
// Dual-write, dual-read register file for the CPU datapath.
// The array has no per-entry reset. A small sequencer clears one entry per
// cycle after reset or on clear_req, so the storage can map onto RAM.
// Port 2 wins when both write ports hit the same entry.
module register_file_dual_write #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int SP_INDEX = 29,
    parameter int SP_INIT  = 227,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              reg_write_1,
    input  logic [ADDR_W-1:0] write_register_1,
    input  logic [DATA_W-1:0] write_data_1,
    input  logic              reg_write_2,
    input  logic [ADDR_W-1:0] write_register_2,
    input  logic [DATA_W-1:0] write_data_2,
    input  logic [ADDR_W-1:0] read_register_1,
    input  logic [ADDR_W-1:0] read_register_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              busy,
    output logic              write_dropped
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SP_ADDR  = ADDR_W'(SP_INDEX);
    localparam logic [DATA_W-1:0] SP_VALUE = DATA_W'(SP_INIT);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] clear_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr1_ok;
    logic              wr2_ok;
    logic [ADDR_W-1:0] read_addr  [2];
    logic [DATA_W-1:0] read_value [2];

    // A write takes effect only in IDLE and never to a hardwired zero entry.
    assign wr1_ok = reg_write_1 && !busy && !(ZERO_REG != 0 && write_register_1 == '0);
    assign wr2_ok = reg_write_2 && !busy && !(ZERO_REG != 0 && write_register_2 == '0);

    // State register: reset always restarts the clear sequence.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= CLEAR;
        else        state <= next_state;
    end

    // Next state: leave CLEAR after the last entry unless a new request restarts it.
    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (!clear_req && clear_idx == '1) next_state = IDLE;
            IDLE:    if (clear_req) next_state = CLEAR;
            default: next_state = CLEAR;
        endcase
    end

    // Output decode: busy comes straight from the registered state.
    always_comb begin
        busy = (state == CLEAR);
    end

    // Clear index: restarts on request, advances while clearing, stops at the last entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clear_idx <= '0;
        end else if (clear_req) begin
            clear_idx <= '0;
        end else if (state == CLEAR && clear_idx != '1) begin
            clear_idx <= clear_idx + 1'b1;
        end
    end

    // Flag any write attempted while the array was being cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) write_dropped <= 1'b0;
        else        write_dropped <= busy && (reg_write_1 || reg_write_2);
    end

    // Array update: the sequencer owns the array in CLEAR, the write ports in IDLE.
    // NOTE: the array is deliberately not reset; the sequencer clears it so it can be a RAM.
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[clear_idx] <= (clear_idx == SP_ADDR) ? SP_VALUE : '0;
        end else begin
            if (wr1_ok) mem[write_register_1] <= write_data_1;
            // NOTE: port 2 is assigned last, so it wins when both ports hit one entry.
            if (wr2_ok) mem[write_register_2] <= write_data_2;
        end
    end

    assign read_addr[0] = read_register_1;
    assign read_addr[1] = read_register_2;

    // Read path: array value, optionally bypassed, then zero-register and busy masking.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            read_value[p] = mem[read_addr[p]];
            if (BYPASS != 0 && wr1_ok && write_register_1 == read_addr[p])
                read_value[p] = write_data_1;
            if (BYPASS != 0 && wr2_ok && write_register_2 == read_addr[p])
                read_value[p] = write_data_2;
            if (ZERO_REG != 0 && read_addr[p] == '0)
                read_value[p] = '0;
            if (busy)
                read_value[p] = '0;
        end
    end

    assign read_data_1 = read_value[0];
    assign read_data_2 = read_value[1];

endmodule

// File: tb/tb_register_file_dual_write.sv
// Directed bench for register_file_dual_write: one instance with bypass,
// one without, sharing every input.
module tb_register_file_dual_write;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear_req = 1'b0;
    logic        reg_write_1 = 1'b0;
    logic [4:0]  write_register_1 = '0;
    logic [31:0] write_data_1 = '0;
    logic        reg_write_2 = 1'b0;
    logic [4:0]  write_register_2 = '0;
    logic [31:0] write_data_2 = '0;
    logic [4:0]  read_register_1 = '0;
    logic [4:0]  read_register_2 = '0;
    logic [31:0] read_data_1, read_data_2, nb_read_data_1, nb_read_data_2;
    logic        busy, write_dropped, nb_busy, nb_write_dropped;

    int checks = 0;
    int errors = 0;

    register_file_dual_write #(.BYPASS(1)) dut (
        .clock(clock), .reset(reset), .clear_req(clear_req),
        .reg_write_1(reg_write_1), .write_register_1(write_register_1), .write_data_1(write_data_1),
        .reg_write_2(reg_write_2), .write_register_2(write_register_2), .write_data_2(write_data_2),
        .read_register_1(read_register_1), .read_register_2(read_register_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .busy(busy), .write_dropped(write_dropped)
    );

    register_file_dual_write #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .clear_req(clear_req),
        .reg_write_1(reg_write_1), .write_register_1(write_register_1), .write_data_1(write_data_1),
        .reg_write_2(reg_write_2), .write_register_2(write_register_2), .write_data_2(write_data_2),
        .read_register_1(read_register_1), .read_register_2(read_register_2),
        .read_data_1(nb_read_data_1), .read_data_2(nb_read_data_2),
        .busy(nb_busy), .write_dropped(nb_write_dropped)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        we2;
        logic [4:0]  wa2;
        logic [31:0] wd2;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;   // expected with bypass
        logic [31:0] e2;
        logic [31:0] n1;   // expected without bypass
        logic [31:0] n2;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_writes();
        reg_write_1 = 1'b0;
        reg_write_2 = 1'b0;
    endtask

    // Counts edges until busy falls, bounded so a stuck sequencer still ends the run.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic read_check(input string name, input logic [4:0] addr, input logic [31:0] exp);
        read_register_1 = addr;
        read_register_2 = addr;
        #1;
        check({name, " rd1"}, read_data_1, exp);
        check({name, " nb rd2"}, nb_read_data_2, exp);
    endtask

    initial begin
        int n;
        int total;

        vecs[0]  = '{1'b1, 5'd8,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    5'd8,  5'd29,
                     32'hDEADBEEF, 32'd227, 32'h0, 32'd227};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,    5'd8,  5'd0,
                     32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 5'd5,  32'h11, 1'b1, 5'd5,  32'h22,   5'd5,  5'd5,
                     32'h22, 32'h22, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,    5'd5,  5'd8,
                     32'h22, 32'hDEADBEEF, 32'h22, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFF, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0,
                     32'h0, 32'h0, 32'h0, 32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,    5'd0,  5'd29,
                     32'h0, 32'd227, 32'h0, 32'd227};
        vecs[6]  = '{1'b1, 5'd10, 32'hA,  1'b1, 5'd11, 32'hB,    5'd10, 5'd11,
                     32'hA, 32'hB, 32'h0, 32'h0};
        vecs[7]  = '{1'b1, 5'd12, 32'h1,  1'b1, 5'd0,  32'h2,    5'd0,  5'd12,
                     32'h0, 32'h1, 32'h0, 32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd29, 32'h1234, 5'd29, 5'd10,
                     32'h1234, 32'hA, 32'd227, 32'hA};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,    5'd29, 5'd11,
                     32'h1234, 32'hB, 32'h1234, 32'hB};
        vecs[10] = '{1'b0, 5'd3,  32'h99, 1'b0, 5'd3,  32'h98,   5'd3,  5'd12,
                     32'h0, 32'h1, 32'h0, 32'h1};

        // Reset held low: sequencer parked, outputs masked.
        tick();
        tick();
        check("reset busy", {31'b0, busy}, 32'd1);
        check("reset dropped", {31'b0, write_dropped}, 32'd0);
        reset = 1'b1;
        read_register_1 = 5'd29;
        #1;
        check("busy masks read", read_data_1, 32'h0);
        count_busy(n);
        check("initial clear cycles", n, 32'd32);
        check("nb idle after clear", {31'b0, nb_busy}, 32'd0);

        // Full array contents after the clear.
        for (int a = 0; a < 32; a++) begin
            read_register_1 = 5'(a);
            read_register_2 = 5'(31 - a);
            #1;
            check($sformatf("clr rd1 a%0d", a), read_data_1, (a == 29) ? 32'd227 : 32'd0);
            check($sformatf("clr nb rd2 a%0d", 31 - a), nb_read_data_2, (31 - a == 29) ? 32'd227 : 32'd0);
        end

        // Table-driven IDLE traffic.
        for (int i = 0; i < 11; i++) begin
            reg_write_1 = vecs[i].we1;
            write_register_1 = vecs[i].wa1;
            write_data_1 = vecs[i].wd1;
            reg_write_2 = vecs[i].we2;
            write_register_2 = vecs[i].wa2;
            write_data_2 = vecs[i].wd2;
            read_register_1 = vecs[i].ra1;
            read_register_2 = vecs[i].ra2;
            #1;
            check($sformatf("vec%0d rd1", i), read_data_1, vecs[i].e1);
            check($sformatf("vec%0d rd2", i), read_data_2, vecs[i].e2);
            check($sformatf("vec%0d nb rd1", i), nb_read_data_1, vecs[i].n1);
            check($sformatf("vec%0d nb rd2", i), nb_read_data_2, vecs[i].n2);
            tick();
            check($sformatf("vec%0d dropped", i), {31'b0, write_dropped}, 32'd0);
            clear_writes();
        end

        // Store 0x55 in entry 3, then request a clear from IDLE.
        reg_write_1 = 1'b1;
        write_register_1 = 5'd3;
        write_data_1 = 32'h55;
        tick();
        clear_writes();
        read_check("pre-clear a3", 5'd3, 32'h55);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clear_req busy", {31'b0, busy}, 32'd1);
        count_busy(n);
        check("clear_req cycles", n, 32'd32);
        read_check("post-clear a3", 5'd3, 32'h0);
        read_check("post-clear a29", 5'd29, 32'd227);
        read_check("post-clear a8", 5'd8, 32'h0);

        // Write attempted on clear cycle 10 to an already-cleared entry.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("dropped before", {31'b0, write_dropped}, 32'd0);
        reg_write_1 = 1'b1;
        write_register_1 = 5'd3;
        write_data_1 = 32'h77;
        reg_write_2 = 1'b1;
        write_register_2 = 5'd4;
        write_data_2 = 32'h78;
        tick();
        clear_writes();
        check("dropped pulse", {31'b0, write_dropped}, 32'd1);
        tick();
        check("dropped cleared", {31'b0, write_dropped}, 32'd0);
        count_busy(n);
        check("busy-write clear cycles", n + 11, 32'd32);
        read_check("dropped a3", 5'd3, 32'h0);
        read_check("dropped a4", 5'd4, 32'h0);

        // Re-request at clear cycle 20: busy runs 32 cycles from the second request.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        count_busy(n);
        total = 20 + n;
        check("restart total cycles", total, 32'd52);

        // Asynchronous reset in the middle of a clear.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        reg_write_1 = 1'b1;
        write_register_1 = 5'd6;
        tick();
        clear_writes();
        check("mid-clear dropped set", {31'b0, write_dropped}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid-clear reset busy", {31'b0, busy}, 32'd1);
        check("mid-clear reset dropped", {31'b0, write_dropped}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        count_busy(n);
        check("mid-clear reset cycles", n, 32'd32);

        // Asynchronous reset while IDLE.
        reg_write_1 = 1'b1;
        write_register_1 = 5'd9;
        write_data_1 = 32'h99;
        tick();
        clear_writes();
        check("idle before reset", {31'b0, busy}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("idle reset busy", {31'b0, busy}, 32'd1);
        check("idle reset dropped", {31'b0, write_dropped}, 32'd0);
        tick();
        reset = 1'b1;
        count_busy(n);
        check("idle reset cycles", n, 32'd32);
        read_check("idle reset a9", 5'd9, 32'h0);
        read_check("idle reset a29", 5'd29, 32'd227);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
